load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 32, number of 32-bit words in the attached data memory; word indices >= MEM_WORDS are out of range.
REQ-002 clock  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  1  start access; sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 sign_ext  input  1  loads only: 1 sign-extends, 0 zero-extends the sub-word result.
REQ-008 byte_addr  input  32  byte address, little-endian.
REQ-009 store_data  input  32  store source; the low 8/16/32 bits are used per size.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 load_data  output  32  extended load result, valid from done and held until the next load completes.
REQ-013 misaligned  output  1  valid with done: halfword with byte_addr[0]=1, word with byte_addr[1:0]!=0, or size=11.
REQ-014 range_err  output  1  valid with done: byte_addr[31:2] >= MEM_WORDS.
REQ-015 mem_read, mem_write  output  1 each  data-memory controls; never high together.
REQ-016 mem_address  output  32  word index {2'b00, byte_addr[31:2]}.
REQ-017 mem_wdata  output  32  word written to memory.
REQ-018 mem_rdata  input  32  memory read result, valid one cycle after the cycle mem_read is high.

Function
REQ-019 FSM states SHALL be IDLE, READ, CAPTURE, WRITE and DONE; all outputs SHALL be decoded from registered state and latched request fields.
REQ-020 In IDLE with req=1, the unit SHALL latch is_store, size, sign_ext, byte_addr and store_data.
REQ-021 From IDLE, a faulting request (misaligned or range_err) SHALL go to DONE with its flag set, issuing no memory access.
REQ-022 From IDLE, a valid word store SHALL go to WRITE, bypassing the read.
REQ-023 From IDLE, any other valid request SHALL go to READ.
REQ-024 READ SHALL drive mem_read=1 for one cycle, then go to CAPTURE.
REQ-025 CAPTURE, load: load_data SHALL take the lane selected by byte_addr[1:0] (byte) or byte_addr[1] (half), extended per sign_ext; word loads take mem_rdata whole; next state DONE.
REQ-026 CAPTURE, sub-word store: the selected lane of mem_rdata SHALL be replaced by store_data[7:0] or [15:0], other lanes preserved; the result is registered; next state WRITE.
REQ-027 WRITE SHALL drive mem_write=1 with mem_wdata for exactly one cycle, then go to DONE.
REQ-028 DONE SHALL pulse done=1 for one cycle, then return to IDLE; the unit accepts a new req on the cycle after DONE.
REQ-029 Latency from req to done SHALL be: fault 1 cycle, word store 2, load 3, sub-word store 4.
REQ-030 req asserted while busy=1 SHALL be ignored, with no queuing.
REQ-031 misaligned and range_err SHALL be 0 outside DONE; both may be set together.
REQ-032 load_data SHALL be unchanged by stores and by faulting accesses.

Reset
REQ-033 When reset=1 at an edge, state SHALL become IDLE and busy, done, misaligned, range_err, mem_read and mem_write SHALL all be 0 from the next cycle.
REQ-034 When reset=1 at an edge, load_data, mem_address and mem_wdata SHALL all be 0 from the next cycle.
REQ-035 Reset mid-operation SHALL abandon the access; no mem_write pulse occurs after the reset edge.

Verification
REQ-036 After reset (memory word k = k): load word at byte_addr 0x14 -> done 3 cycles after req, load_data=0x00000005.
REQ-037 Store byte 0xAB at 0x0D, then load word at 0x0C -> load_data=0x0000AB03; then load signed byte at 0x0D -> 0xFFFFFFAB; load unsigned byte at 0x0D -> 0x000000AB.
REQ-038 Store halfword at 0x0B -> done 1 cycle after req, misaligned=1, no mem_read or mem_write pulse; load_data unchanged.
REQ-039 Load word at 0x80 with MEM_WORDS=32 -> range_err=1, misaligned=0, no memory access.
REQ-040 Reset asserted during READ of a byte store -> mem_write never asserted, busy=0 on the next cycle, memory word unchanged.
REQ-041 Second req pulsed during a load's CAPTURE -> ignored; exactly one done pulse is observed.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a core and a word-addressed data memory.
// Sub-word stores are done as read-modify-write; every output is a register.
module load_store_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_i,
   input  logic        is_store_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [31:0] byte_addr_i,
   input  logic [31:0] store_data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o,
   output logic        range_err_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

   localparam logic [29:0] MemWordsLimit = 30'(MEM_WORDS);

   state_t      state_q;
   logic        isStore_q;
   logic [1:0]  size_q;
   logic        signExt_q;
   logic [1:0]  addrLow_q;
   logic [15:0] storeLow_q;
   logic        busy_q, done_q, misaligned_q, rangeErr_q, memRead_q, memWrite_q;
   logic [31:0] loadData_q, memAddress_q, memWdata_q;

   logic        reqMisaligned, reqRangeErr;
   logic [4:0]  laneShift;
   logic [31:0] laneData, laneMask, loadResult, mergedWord;

   assign reqMisaligned = (size_i == 2'b11) ||
                          ((size_i == 2'b01) && byte_addr_i[0]) ||
                          ((size_i == 2'b10) && (byte_addr_i[1:0] != 2'b00));
   assign reqRangeErr   = (byte_addr_i[31:2] >= MemWordsLimit);

   // Halfwords are aligned here, so the byte-lane shift also selects the half.
   always_comb begin
      laneShift  = {addrLow_q, 3'b000};
      laneData   = mem_rdata_i >> laneShift;
      laneMask   = (size_q == 2'b00) ? (32'h0000_00FF << laneShift)
                                     : (32'h0000_FFFF << laneShift);
      mergedWord = (mem_rdata_i & ~laneMask) |
                   ((32'(storeLow_q) << laneShift) & laneMask);
      case (size_q)
         2'b00:   loadResult = {{24{signExt_q & laneData[7]}}, laneData[7:0]};
         2'b01:   loadResult = {{16{signExt_q & laneData[15]}}, laneData[15:0]};
         default: loadResult = mem_rdata_i;
      endcase
   end

   // Control FSM; pulse outputs default low each cycle and are raised on entry.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         isStore_q    <= 1'b0;
         size_q       <= 2'b00;
         signExt_q    <= 1'b0;
         addrLow_q    <= 2'b00;
         storeLow_q   <= 16'h0000;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         rangeErr_q   <= 1'b0;
         memRead_q    <= 1'b0;
         memWrite_q   <= 1'b0;
         loadData_q   <= 32'h0;
         memAddress_q <= 32'h0;
         memWdata_q   <= 32'h0;
      end else begin
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         rangeErr_q   <= 1'b0;
         memRead_q    <= 1'b0;
         memWrite_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  isStore_q    <= is_store_i;
                  size_q       <= size_i;
                  signExt_q    <= sign_ext_i;
                  addrLow_q    <= byte_addr_i[1:0];
                  storeLow_q   <= store_data_i[15:0];
                  memAddress_q <= {2'b00, byte_addr_i[31:2]};
                  busy_q       <= 1'b1;
                  if (reqMisaligned || reqRangeErr) begin
                     misaligned_q <= reqMisaligned;
                     rangeErr_q   <= reqRangeErr;
                     done_q       <= 1'b1;
                     state_q      <= DONE;
                  end else if (is_store_i && (size_i == 2'b10)) begin
                     memWdata_q <= store_data_i;
                     memWrite_q <= 1'b1;
                     state_q    <= WRITE;
                  end else begin
                     memRead_q <= 1'b1;
                     state_q   <= READ;
                  end
               end
            end
            READ: state_q <= CAPTURE;
            CAPTURE: begin
               if (isStore_q) begin
                  memWdata_q <= mergedWord;
                  memWrite_q <= 1'b1;
                  state_q    <= WRITE;
               end else begin
                  loadData_q <= loadResult;
                  done_q     <= 1'b1;
                  state_q    <= DONE;
               end
            end
            WRITE: begin
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign load_data_o   = loadData_q;
   assign misaligned_o  = misaligned_q;
   assign range_err_o   = rangeErr_q;
   assign mem_read_o    = memRead_q;
   assign mem_write_o   = memWrite_q;
   assign mem_address_o = memAddress_q;
   assign mem_wdata_o   = memWdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 32-word memory model
// preloaded with word k = k.
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        req, isStore, signExt;
   logic [1:0]  size;
   logic [31:0] byteAddr, storeData;
   logic        busy, done, misaligned, rangeErr, memRead, memWrite;
   logic [31:0] loadData, memAddress, memWdata;
   logic [31:0] memRdata;

   logic [31:0] mem [32];
   logic        memInit;

   int vectors = 0;
   int miscompares = 0;
   int readPulses = 0;
   int writePulses = 0;
   int donePulses = 0;
   int overlapCycles = 0;

   load_store_unit #(.MEM_WORDS(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_i        (req),
      .is_store_i   (isStore),
      .size_i       (size),
      .sign_ext_i   (signExt),
      .byte_addr_i  (byteAddr),
      .store_data_i (storeData),
      .busy_o       (busy),
      .done_o       (done),
      .load_data_o  (loadData),
      .misaligned_o (misaligned),
      .range_err_o  (rangeErr),
      .mem_read_o   (memRead),
      .mem_write_o  (memWrite),
      .mem_address_o(memAddress),
      .mem_wdata_o  (memWdata),
      .mem_rdata_i  (memRdata)
   );

   always #5 clock = ~clock;

   // Synchronous memory: read data appears the cycle after mem_read.
   always @(posedge clock) begin
      if (memInit) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
         memRdata <= 32'h0;
      end else begin
         if (memRead) memRdata <= mem[memAddress[4:0]];
         if (memWrite) mem[memAddress[4:0]] <= memWdata;
      end
   end

   // Pulse counters sampled mid-cycle.
   always @(negedge clock) begin
      if (memRead) readPulses++;
      if (memWrite) writePulses++;
      if (done) donePulses++;
      if (memRead && memWrite) overlapCycles++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Issue one access and wait (bounded) for done; flags are captured with done.
   task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sx,
                                input logic [31:0] addr, input logic [31:0] data,
                                output int lat, output logic mis, output logic rerr,
                                output int rd, output int wr);
      int rd0, wr0;
      rd0 = readPulses;
      wr0 = writePulses;
      @(negedge clock);
      isStore = st; size = sz; signExt = sx; byteAddr = addr; storeData = data;
      req = 1'b1;
      lat = 0;
      do begin
         @(posedge clock);
         #1;
         req = 1'b0;
         lat++;
      end while (!done && lat < 10);
      if (!done) lat = 99;
      mis  = misaligned;
      rerr = rangeErr;
      @(posedge clock);
      #1;
      checkOutput("doneOneCycle", {31'b0, done}, 32'h0);
      checkOutput("idleAfterDone", {31'b0, busy}, 32'h0);
      checkOutput("flagClearedAfterDone", {30'b0, misaligned, rangeErr}, 32'h0);
      rd = readPulses - rd0;
      wr = writePulses - wr0;
   endtask

   initial begin
      int lat, rd, wr, wr0, d0;
      logic mis, rerr;

      req = 1'b0; isStore = 1'b0; size = 2'b00; signExt = 1'b0;
      byteAddr = 32'h0; storeData = 32'h0;
      reset = 1'b1;
      memInit = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rstBusy", {31'b0, busy}, 32'h0);
      checkOutput("rstDone", {31'b0, done}, 32'h0);
      checkOutput("rstFlags", {30'b0, misaligned, rangeErr}, 32'h0);
      checkOutput("rstMemCtl", {30'b0, memRead, memWrite}, 32'h0);
      checkOutput("rstLoadData", loadData, 32'h0);
      checkOutput("rstMemAddr", memAddress, 32'h0);
      checkOutput("rstMemWdata", memWdata, 32'h0);
      reset = 1'b0;
      memInit = 1'b0;

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldW14Lat", lat, 3);
      checkOutput("ldW14Data", loadData, 32'h0000_0005);
      checkOutput("ldW14Flags", {30'b0, mis, rerr}, 32'h0);
      checkOutput("ldW14Reads", rd, 1);
      checkOutput("ldW14Writes", wr, 0);

      applyStimulus(1'b1, 2'b00, 1'b0, 32'h0D, 32'h1234_56AB, lat, mis, rerr, rd, wr);
      checkOutput("stB0DLat", lat, 4);
      checkOutput("stB0DMem", mem[3], 32'h0000_AB03);
      checkOutput("stB0DWrites", wr, 1);
      checkOutput("stB0DKeepsLoad", loadData, 32'h0000_0005);

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldW0CData", loadData, 32'h0000_AB03);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldSB0D", loadData, 32'hFFFF_FFAB);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldUB0D", loadData, 32'h0000_00AB);

      applyStimulus(1'b1, 2'b01, 1'b0, 32'h0B, 32'hFFFF_FFFF, lat, mis, rerr, rd, wr);
      checkOutput("stH0BLat", lat, 1);
      checkOutput("stH0BFlags", {30'b0, mis, rerr}, 32'h2);
      checkOutput("stH0BNoAccess", rd + wr, 0);
      checkOutput("stH0BKeepsLoad", loadData, 32'h0000_00AB);

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldW80Lat", lat, 1);
      checkOutput("ldW80Flags", {30'b0, mis, rerr}, 32'h1);
      checkOutput("ldW80NoAccess", rd + wr, 0);

      applyStimulus(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldRsvdFlags", {30'b0, mis, rerr}, 32'h2);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h81, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldW81BothFlags", {30'b0, mis, rerr}, 32'h3);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, lat, mis, rerr, rd, wr);
      checkOutput("stW20Lat", lat, 2);
      checkOutput("stW20Mem", mem[8], 32'hDEAD_BEEF);
      checkOutput("stW20Access", {rd[15:0], wr[15:0]}, 32'h0000_0001);

      applyStimulus(1'b1, 2'b01, 1'b0, 32'h1A, 32'h9999_5A5A, lat, mis, rerr, rd, wr);
      checkOutput("stH1ALat", lat, 4);
      checkOutput("stH1AMem", mem[6], 32'h5A5A_0006);

      applyStimulus(1'b0, 2'b01, 1'b1, 32'h1A, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldSH1A", loadData, 32'h0000_5A5A);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldSH22", loadData, 32'hFFFF_DEAD);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, lat, mis, rerr, rd, wr);
      checkOutput("ldUH20", loadData, 32'h0000_BEEF);

      // Reset arriving while a byte store is in READ.
      @(negedge clock);
      isStore = 1'b1; size = 2'b00; signExt = 1'b0; byteAddr = 32'h10; storeData = 32'h77;
      req = 1'b1;
      @(posedge clock);
      #1;
      req = 1'b0;
      checkOutput("rstMidReadPhase", {30'b0, busy, memRead}, 32'h3);
      wr0 = writePulses;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("rstMidBusy", {31'b0, busy}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      checkOutput("rstMidNoWrite", writePulses - wr0, 0);
      checkOutput("rstMidMem", mem[4], 32'h0000_0004);

      // A second request during a load's CAPTURE must be dropped.
      d0 = donePulses;
      wr0 = writePulses;
      @(negedge clock);
      isStore = 1'b0; size = 2'b10; byteAddr = 32'h14;
      req = 1'b1;
      @(posedge clock);
      #1;
      req = 1'b0;
      @(posedge clock);
      @(negedge clock);
      isStore = 1'b1; size = 2'b10; byteAddr = 32'h0; storeData = 32'hFFFF_FFFF;
      req = 1'b1;
      @(posedge clock);
      #1;
      req = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      checkOutput("busyReqDonePulses", donePulses - d0, 1);
      checkOutput("busyReqNoWrite", writePulses - wr0, 0);
      checkOutput("busyReqMem0", mem[0], 32'h0);
      checkOutput("busyReqLoad", loadData, 32'h0000_0005);

      checkOutput("readWriteOverlap", overlapCycles, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
